// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; head entry is read combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A push on a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited requests, in-order response
// buffering and redirect flush with stale-response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1);
  localparam int unsigned FC_W  = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      fetch_pc, fetch_pc_n;
  logic [31:0]      resp_pc, resp_pc_n;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic [CNT_W-1:0] drop_cnt, drop_cnt_n;
  logic [FC_W-1:0]  fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic             req_fire;
  logic             resp_drop;
  logic             resp_keep;
  logic             push;
  logic             pop;

  // Credit: every live request must already own a FIFO slot.
  assign imem_req_valid = !rst && ((SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_drop      = imem_resp_valid && (drop_cnt != '0);
  assign resp_keep      = imem_resp_valid && (drop_cnt == '0);
  assign push           = resp_keep && !redirect_valid;
  assign instr_valid    = !fifo_empty;
  assign pop            = instr_valid && instr_ready;
  assign push_entry     = '{instr: imem_resp_data, pc: resp_pc};
  assign instr          = head_entry.instr;
  assign instr_pc       = head_entry.pc;

  always_comb begin
    fetch_pc_n    = fetch_pc;
    resp_pc_n     = resp_pc;
    outstanding_n = outstanding;
    drop_cnt_n    = drop_cnt;
    if (redirect_valid) begin
      // Everything still in flight, including this cycle's request, becomes stale.
      fetch_pc_n    = align_word(redirect_pc);
      resp_pc_n     = align_word(redirect_pc);
      outstanding_n = '0;
      drop_cnt_n    = drop_cnt + outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_n = fetch_pc + 32'(INSTR_BYTES);
      if (push)     resp_pc_n  = resp_pc + 32'(INSTR_BYTES);
      outstanding_n = outstanding + CNT_W'(req_fire) - CNT_W'(resp_keep);
      if (resp_drop) drop_cnt_n = drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      resp_pc     <= resp_pc_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect_valid),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  push_on_full_a: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable latency and
// an in-order pc scoreboard checked on every decode handshake.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic        stall_prev;
  logic [31:0] stall_addr;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    lat = 1;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: in-order, fixed latency, one response per cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mem_q.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready)
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat - 1});
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the negedge, update the model, advance.
  task automatic tick();
    logic        hs;
    logic        pp;
    logic [31:0] e;
    #1;
    hs = imem_req_valid && imem_req_ready;
    pp = instr_valid && instr_ready;
    check("req_valid", 32'(imem_req_valid), 32'(!rst && (exp_q.size() < int'(DEPTH))));
    if (rst) begin
      exp_q.delete();
      exp_fetch  = RESET_PC;
      stall_prev = 1'b0;
    end else begin
      if (pp) begin
        e = (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF;
        check("deliver_pc", instr_pc, e);
        check("deliver_instr", instr, word(e));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (hs) check("req_addr", imem_req_addr, exp_fetch);
      if (stall_prev) check("stall_addr", imem_req_addr, stall_addr);
      if (redirect_valid) begin
        exp_q.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
      end else if (hs) begin
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      stall_prev = imem_req_valid && !imem_req_ready && !redirect_valid;
      stall_addr = imem_req_addr;
    end
    @(negedge clk);
  endtask

  task automatic wait_head(input string tag, input logic [31:0] pc);
    int n;
    n = 0;
    instr_ready = 1'b0;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check(tag, instr_pc, pc);
  endtask

  task automatic quiesce();
    int n;
    n = 0;
    imem_req_ready = 1'b0;
    while ((mem_q.size() != 0 || imem_resp_valid) && n < 30) begin
      tick();
      n++;
    end
    check("quiesce", 32'(mem_q.size()), 32'd0);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] pc);
    check(tag, instr_pc, pc);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    exp_fetch      = RESET_PC;
    stall_prev     = 1'b0;
    stall_addr     = 32'h0;
    @(negedge clk);
    repeat (2) tick();
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);

    // Streaming with single-cycle memory and an always-ready decoder.
    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    tick();
    check("t1_no_bypass", 32'(instr_valid), 32'd0);
    tick();
    check("t1_latency_valid", 32'(instr_valid), 32'd1);
    check("t1_latency_pc", instr_pc, 32'h0);
    repeat (12) tick();

    // Decode stalled: fetch stops after DEPTH requests, then resumes.
    rst = 1'b1; tick(); rst = 1'b0;
    instr_ready = 1'b0;
    repeat (8) tick();
    check("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_full_next_addr", imem_req_addr, 32'h10);
    check("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    check("t2_resume_valid", 32'(imem_req_valid), 32'd1);
    check("t2_resume_addr", imem_req_addr, 32'h10);
    repeat (10) tick();

    // Redirect with three requests in flight.
    quiesce(); repeat (4) tick(); lat = 4;
    imem_req_ready = 1'b1;
    repeat (3) tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1003;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    check("t3_flushed", 32'(instr_valid), 32'd0);
    check("t3_new_addr", imem_req_addr, 32'h1000);
    wait_head("t3_first_pc", 32'h1000);
    instr_ready = 1'b1;
    repeat (8) tick();

    // Redirect coinciding with a request handshake and a response.
    quiesce(); repeat (4) tick(); lat = 2;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    n = 0;
    while (!(imem_resp_valid && imem_req_valid) && n < 20) begin
      tick();
      n++;
    end
    check("t4_setup", 32'(imem_resp_valid && imem_req_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h1000;
    tick();
    redirect_valid = 1'b0;
    wait_head("t4_first_pc", 32'h1000);
    instr_ready = 1'b1;
    repeat (10) tick();

    // Random memory and decode backpressure.
    quiesce(); lat = 1;
    for (int i = 0; i < 80; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      instr_ready    = 1'($urandom_range(0, 1));
      tick();
    end
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (6) tick();

    // Address wrap at the top of memory.
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    pop_check("t6_pc_fff8", 32'hFFFF_FFF8);
    pop_check("t6_pc_fffc", 32'hFFFF_FFFC);
    pop_check("t6_pc_0000", 32'h0000_0000);

    // Reset with a full FIFO.
    repeat (4) tick();
    check("t7_full", 32'(imem_req_valid), 32'd0);
    check("t7_full_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("t7_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("t7_rst_addr", imem_req_addr, RESET_PC);
    check("t7_rst_instr_pc", instr_pc, 32'd0);
    check("t7_rst_instr", instr, 32'd0);
    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
